// File: rtl/ct_idu_is_aiq_lch_sched.sv
// ---------------------------------------------------------------------------
// ct_idu_is_aiq_lch_sched
//
// Launch scheduler for one ALU issue queue. It allocates free entries to up
// to two creates per cycle and keeps a relative-age matrix. Each cycle it
// picks the oldest valid entry whose source launch-ready bits are all set.
// That pick is held in a registered issue slot until the execution pipe
// accepts it.
//
// Ports
//   y_clk          clock, all state updates on the rising edge
//   cpurst         synchronous active-high reset
//   create0_en     create request, port 0 (older of a pair)
//   create1_en     create request, port 1 (younger); only honoured with port 0
//   entry_lch_rdy  per-entry source-ready bits, entry i at [i*SRC +: SRC]
//   flush          invalidates the whole queue and the issue slot
//   pipe_stall     pipe cannot accept the held issue this cycle
//   alloc0_entry   one-hot lowest free entry (0 if none)
//   alloc1_entry   one-hot second-lowest free entry (0 if fewer than two)
//   alloc0_rdy     at least one entry free
//   alloc1_rdy     at least two entries free
//   entry_vld      per-entry valid
//   issue_vld      issue slot holds an entry
//   issue_entry    one-hot entry held in the issue slot
//   issue_ptr      binary index of issue_entry
//   entry_cnt      number of valid entries
//   full / empty   entry_cnt == ENTRY / entry_cnt == 0
//
// No output depends combinationally on any input; every output is a
// function of registered state only.
// ---------------------------------------------------------------------------
module ct_idu_is_aiq_lch_sched #(
  parameter int ENTRY = 8,
  parameter int SRC   = 3,
  parameter int PTRW  = 3
) (
  input  logic                   y_clk,
  input  logic                   cpurst,
  input  logic                   create0_en,
  input  logic                   create1_en,
  input  logic [ENTRY*SRC-1:0]   entry_lch_rdy,
  input  logic                   flush,
  input  logic                   pipe_stall,
  output logic [ENTRY-1:0]       alloc0_entry,
  output logic [ENTRY-1:0]       alloc1_entry,
  output logic                   alloc0_rdy,
  output logic                   alloc1_rdy,
  output logic [ENTRY-1:0]       entry_vld,
  output logic                   issue_vld,
  output logic [ENTRY-1:0]       issue_entry,
  output logic [PTRW-1:0]        issue_ptr,
  output logic [PTRW:0]          entry_cnt,
  output logic                   full,
  output logic                   empty
);

  localparam int CNTW = PTRW + 1;

  // -------------------------------------------------------------------------
  // State
  //   vld            per-entry valid
  //   age[j][i] = 1  entry j is older than entry i
  //   issue slot     issue_vld / issue_entry (registered outputs)
  // -------------------------------------------------------------------------
  logic [ENTRY-1:0]             vld;
  logic [ENTRY-1:0][ENTRY-1:0]  age;

  logic [ENTRY-1:0]             vld_nxt;
  logic [ENTRY-1:0][ENTRY-1:0]  age_nxt;

  logic [ENTRY-1:0]             free;
  logic [ENTRY-1:0]             free_rest;
  logic [ENTRY-1:0]             elig;
  logic [ENTRY-1:0]             sel;

  logic                         do_create0;
  logic                         do_create1;
  logic                         accept;
  logic                         load;

  // -------------------------------------------------------------------------
  // Allocation: lowest and second-lowest free entries from the current vld.
  // A freed entry only shows up here once its vld has actually cleared, so
  // it is never handed out in the cycle it is being accepted.
  // -------------------------------------------------------------------------
  // NOTE: every variable assigned in always_comb gets a default before any
  // conditional assignment, so no latch can be inferred; blocking '=' is
  // correct here because these are combinational temporaries.
  always_comb begin
    free         = ~vld;
    alloc0_entry = '0;
    for (int i = ENTRY - 1; i >= 0; i--) begin
      if (free[i]) begin
        alloc0_entry    = '0;
        alloc0_entry[i] = 1'b1;
      end
    end

    free_rest    = free & ~alloc0_entry;
    alloc1_entry = '0;
    for (int i = ENTRY - 1; i >= 0; i--) begin
      if (free_rest[i]) begin
        alloc1_entry    = '0;
        alloc1_entry[i] = 1'b1;
      end
    end

    alloc0_rdy = |free;
    alloc1_rdy = |free_rest;
  end

  // Creates without a matching free entry are silently dropped; port 1 is
  // meaningful only as the younger half of a pair with port 0.
  assign do_create0 = create0_en & alloc0_rdy;
  assign do_create1 = create0_en & create1_en & alloc1_rdy;

  // The slot reloads whenever it is empty or its content leaves this cycle.
  assign accept = issue_vld & ~pipe_stall;
  assign load   = ~issue_vld | ~pipe_stall;

  // -------------------------------------------------------------------------
  // Eligibility and oldest-ready select. The entry already sitting in the
  // issue slot is excluded, so a reload in the accept cycle never picks the
  // entry that is leaving.
  // -------------------------------------------------------------------------
  always_comb begin
    elig = '0;
    sel  = '0;
    for (int i = 0; i < ENTRY; i++) begin
      elig[i] = vld[i] & (&entry_lch_rdy[i*SRC +: SRC])
              & ~(issue_vld & issue_entry[i]);
    end
    for (int i = 0; i < ENTRY; i++) begin
      sel[i] = elig[i];
      for (int j = 0; j < ENTRY; j++) begin
        if (j != i && elig[j] && age[j][i]) begin
          sel[i] = 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state for vld and the age matrix.
  //   create of n : column n <- current vld, row n <- 0
  //   dual create : the port-0 entry is also older than the port-1 entry
  //   accept of n : row n and column n cleared
  // Port 0 is processed before port 1 so that clearing row alloc0 cannot
  // erase the age[alloc0][alloc1] bit.
  // -------------------------------------------------------------------------
  always_comb begin
    vld_nxt = vld;
    age_nxt = age;

    if (do_create0) begin
      vld_nxt = vld_nxt | alloc0_entry;
      for (int n = 0; n < ENTRY; n++) begin
        if (alloc0_entry[n]) begin
          for (int r = 0; r < ENTRY; r++) begin
            age_nxt[r][n] = vld[r];
          end
          age_nxt[n] = '0;
        end
      end
    end

    if (do_create1) begin
      vld_nxt = vld_nxt | alloc1_entry;
      for (int n = 0; n < ENTRY; n++) begin
        if (alloc1_entry[n]) begin
          for (int r = 0; r < ENTRY; r++) begin
            age_nxt[r][n] = vld[r] | alloc0_entry[r];
          end
          age_nxt[n] = '0;
        end
      end
    end

    if (accept) begin
      vld_nxt = vld_nxt & ~issue_entry;
      for (int n = 0; n < ENTRY; n++) begin
        if (issue_entry[n]) begin
          age_nxt[n] = '0;
          for (int r = 0; r < ENTRY; r++) begin
            age_nxt[r][n] = 1'b0;
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers. Flush shares the reset path: it wins over creates and
  // accepts in the same cycle and empties the issue slot.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking '<=' only, so every register
  // samples the pre-edge values of the others. The age matrix is reset along
  // with vld: it is small flop storage, and a clean matrix keeps stale order
  // bits from ever being observable.
  always_ff @(posedge y_clk) begin
    if (cpurst || flush) begin
      vld         <= '0;
      age         <= '0;
      issue_vld   <= 1'b0;
      issue_entry <= '0;
    end else begin
      vld <= vld_nxt;
      age <= age_nxt;
      if (load) begin
        issue_vld   <= |sel;
        issue_entry <= sel;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Derived outputs
  // -------------------------------------------------------------------------
  assign entry_vld = vld;

  always_comb begin
    issue_ptr = '0;
    for (int i = 0; i < ENTRY; i++) begin
      if (issue_entry[i]) begin
        issue_ptr = PTRW'(i);
      end
    end
  end

  always_comb begin
    entry_cnt = '0;
    for (int i = 0; i < ENTRY; i++) begin
      entry_cnt = entry_cnt + CNTW'(vld[i]);
    end
  end

  assign full  = (entry_cnt == CNTW'(ENTRY));
  assign empty = (entry_cnt == '0);

endmodule

// File: doc/ct_idu_is_aiq_lch_sched.md
# ct_idu_is_aiq_lch_sched

Launch scheduler for one ALU issue queue (AIQ). It allocates free entries to up to two creates per cycle and tracks relative entry age in an age matrix. Each cycle it selects the oldest valid entry whose per-source launch-ready bits are all set, then holds that selection in a registered issue slot until the execution pipe accepts it. It sits between the per-entry launch-ready registers, which supply ready bits with create bypass already applied, and the execution pipe's launch port.

## Interface
Parameters:
- ENTRY, 8, number of queue entries (≥2)
- SRC, 3, source operands per entry
- PTRW, 3, log2(ENTRY)

Ports:
- y_clk  in  1  clock
- cpurst  in  1  synchronous, active-high reset
- create0_en  in  1  create request, port 0 (older)
- create1_en  in  1  create request, port 1 (younger); legal only together with create0_en
- entry_lch_rdy  in  ENTRY*SRC  entry i source-ready bits at [i*SRC +: SRC]
- flush  in  1  pipeline flush; invalidates the whole queue
- pipe_stall  in  1  pipe cannot accept this cycle
- alloc0_entry  out  ENTRY  one-hot lowest-index free entry (0 if none)
- alloc1_entry  out  ENTRY  one-hot second-lowest free entry (0 if <2 free)
- alloc0_rdy / alloc1_rdy  out  1  ≥1 / ≥2 entries free
- entry_vld  out  ENTRY  per-entry valid
- issue_vld  out  1  issue slot holds an entry
- issue_entry  out  ENTRY  one-hot issued entry
- issue_ptr  out  PTRW  encoded issue_entry
- entry_cnt  out  PTRW+1  number of valid entries
- full / empty  out  1  entry_cnt==ENTRY / entry_cnt==0

## Operation
- State: vld[ENTRY], age[ENTRY][ENTRY] (age[j][i]=1 ⇒ j older than i), issue slot {issue_vld, issue_entry}.
- Allocation is combinational from the current vld. create0_en && alloc0_rdy sets vld[alloc0]. create1_en && create0_en && alloc1_rdy sets vld[alloc1]. Any create without its rdy is dropped. create1_en without create0_en is ignored.
- Age update on create of entry n: column n ← vld (every current valid entry is older than n); row n ← 0. With dual create, age[alloc0][alloc1]=1.
- Eligible: elig[i] = vld[i] & (&entry_lch_rdy[i]) & ~(issue_vld & issue_entry[i]).
- Select: sel[i] = elig[i] & ~|(elig[j] & age[j][i]) over j≠i. At most one bit is set.
- Issue slot load condition: load = ~issue_vld | ~pipe_stall.
- Accept: issue_vld & ~pipe_stall. On accept, vld[issue_entry] clears at that edge and its age row/column clears.
- On load, the slot takes issue_vld ← |sel and issue_entry ← sel. sel already excludes the entry being accepted.
- A stalled slot holds issue_entry unchanged regardless of later, older ready entries.
- flush has priority over everything: at the edge vld, age and issue_vld/issue_entry clear. Creates and accepts in the same cycle are discarded.
- entry_cnt is the popcount of vld. full and empty are derived from it.

## Timing
- All state is updated on the y_clk rising edge. Outputs come from registers or from registered state through combinational logic; there is no input-to-output combinational path except from none.
- Reset (cpurst=1 at an edge): vld=0, age=0, issue_vld=0, issue_entry=0, issue_ptr=0, entry_cnt=0, empty=1, full=0, alloc0_entry=0x01, alloc1_entry=0x02, alloc0_rdy=alloc1_rdy=1. Reset during a held issue drops the issue with no accept.
- Create-to-issue latency with all sources ready at create: create in cycle N → entry_vld in N+1 → issue_vld in N+2.
- Back-to-back issue: a new entry loads at the same edge as the previous one is accepted, so one issue per cycle is sustained.
- An accepted entry is reallocatable from the cycle after acceptance, never in the acceptance cycle.
- Full: alloc0_rdy=0, and creates are dropped with no state change.

## Test plan
- Reset then single create with entry_lch_rdy all 1 → alloc0_entry 0x01; issue_vld=1 with issue_entry=0x01 two cycles later; accept → entry_vld=0, empty=1.
- Create entries 0,1,2 in successive cycles with ready bits 0, then set all ready in one cycle → issues 0x01, 0x02, 0x04 on consecutive cycles.
- Dual create into an empty queue, both ready → entry0 (port 0) issues before entry1.
- Issue entry 3 with pipe_stall=1 for 4 cycles while an older entry becomes ready → issue_entry stays 0x08 until the stall drops, then the older entry issues next.
- Fill all 8 entries (entry_cnt=8, full=1) → next create is dropped and alloc0_rdy=0; one accept → alloc0_entry equals the freed entry the following cycle.
- flush asserted with issue_vld=1, create0_en=1 and an accept all in the same cycle → next cycle entry_vld=0, issue_vld=0, entry_cnt=0.
